alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised successor of the execute-stage ALU: keeps the single-cycle combinational operations and adds iterative multiply/divide with architectural HI/LO registers. Multi-cycle ops run under a start/busy/done handshake; `busy` stalls the pipeline hazard unit. Sits in EXE, between the ID/EXE register and the EXE/MEM register.

## Interface
- `SIZE`, 32, operand/result width (even, ≥ 4)
- `COM_SIZE`, 4, command width
- `clk` input 1: sole clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `start` input 1: EXE-stage instruction valid; launches MULT/MULTU/DIV/DIVU
- `EXE_CMD` input COM_SIZE: operation code
- `val1`, `val2` input SIZE: operands
- `aluOut` output SIZE: combinational result of single-cycle ops and MFHI/MFLO
- `busy` output 1: multi-cycle op in flight
- `done` output 1: one-cycle pulse when HI/LO are written
- `hiOut`, `loOut` output SIZE: current HI/LO

## Operation
- Codes: ADD 0, SUB 1, AND 2, OR 3, NOR 4, XOR 5, SLA 6, SLL 7, SRA 8, SRL 9, MULT 10, MULTU 11, DIV 12, DIVU 13, MFHI 14, MFLO 15.
- Shifts use `val2[$clog2(SIZE)-1:0]`; SLA/SLL logical left, SRL logical right, SRA arithmetic right (sign fill).
- MFHI/MFLO: `aluOut` = HI/LO. MULT..DIVU: `aluOut` = 0.
- FSM: IDLE → RUN → FIN → IDLE.
- IDLE: `start` with a MULT/DIV code latches magnitudes of operands (signed ops) plus result sign flags and clears the iteration counter → RUN. Other codes never leave IDLE.
- RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle, SIZE steps → FIN.
- FIN: apply sign correction, write HI/LO, pulse `done` → IDLE.
- Multiply: {HI,LO} = full 2·SIZE-bit product.
- Divide: LO = quotient, HI = remainder; quotient truncates toward zero, remainder takes dividend's sign.
- Divide by zero: LO = all ones, HI = val1; normal latency.
- Signed MIN / −1: LO = MIN, HI = 0.
- `start` while `busy`: ignored. Operands and `EXE_CMD` are not required to be held after launch.
- MFHI/MFLO while `busy`: return the pre-operation HI/LO. The hazard unit stalls on `busy`.

## Timing
- Reset: state IDLE, HI = LO = 0, `busy` = 0, `done` = 0, counter 0. Reset mid-operation aborts with no HI/LO write.
- Launch edge = cycle 0.
- `busy` is high cycles 1..SIZE+1.
- FIN occupies cycle SIZE+1; HI/LO are visible and `done` is high in cycle SIZE+2. `busy` is low the same cycle.
- A new launch is accepted in the cycle `done` is high; back-to-back throughput is SIZE+2 cycles.
- Single-cycle ops have zero latency and work while `busy`.

## Configuration
- `ALU_DIV_EN` defined: divider datapath compiled in, as above.
- Not defined: DIV/DIVU launch nothing; `busy` stays 0, HI/LO are unchanged, and `done` pulses once in cycle 1. Multiply is unaffected.

## Structure
- Shared package `alu_pkg`: COM_SIZE, all EXE_* codes, FSM state enum.
- Sub-module `alu_muldiv_core`: FSM, counter, partial remainder/product registers, sign fix-up, HI/LO.
- Top level: combinational ops and output mux.

## Test plan
All cases SIZE = 32.
- SRA 0x80000000 by 4 → 0xF8000000. SRL → 0x08000000. SLL 1 by 31 → 0x80000000.
- MULT 0xFFFFFFFF × 2 → HI 0xFFFFFFFF, LO 0xFFFFFFFE. MULTU same operands → HI 1, LO 0xFFFFFFFE. `done` in cycle 34.
- DIV −7 / 2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF. DIVU 7/0 → LO 0xFFFFFFFF, HI 7. DIV 0x80000000 / −1 → LO 0x80000000, HI 0.
- MFLO during busy returns old LO. Second `start` while busy is ignored. Launch on the `done` cycle is accepted.
- Assert `rst` at cycle 10 of a MULT → HI = LO = 0, `busy` = 0 immediately, no `done`.
- Without `ALU_DIV_EN`: DIV 9/3 → `busy` never set, `done` in cycle 1, HI/LO unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative execute-stage ALU: command width, opcodes, FSM states.
package alu_pkg;

  localparam int unsigned COM_SIZE = 4;

  localparam logic [COM_SIZE-1:0] EXE_ADD   = COM_SIZE'(0);
  localparam logic [COM_SIZE-1:0] EXE_SUB   = COM_SIZE'(1);
  localparam logic [COM_SIZE-1:0] EXE_AND   = COM_SIZE'(2);
  localparam logic [COM_SIZE-1:0] EXE_OR    = COM_SIZE'(3);
  localparam logic [COM_SIZE-1:0] EXE_NOR   = COM_SIZE'(4);
  localparam logic [COM_SIZE-1:0] EXE_XOR   = COM_SIZE'(5);
  localparam logic [COM_SIZE-1:0] EXE_SLA   = COM_SIZE'(6);
  localparam logic [COM_SIZE-1:0] EXE_SLL   = COM_SIZE'(7);
  localparam logic [COM_SIZE-1:0] EXE_SRA   = COM_SIZE'(8);
  localparam logic [COM_SIZE-1:0] EXE_SRL   = COM_SIZE'(9);
  localparam logic [COM_SIZE-1:0] EXE_MULT  = COM_SIZE'(10);
  localparam logic [COM_SIZE-1:0] EXE_MULTU = COM_SIZE'(11);
  localparam logic [COM_SIZE-1:0] EXE_DIV   = COM_SIZE'(12);
  localparam logic [COM_SIZE-1:0] EXE_DIVU  = COM_SIZE'(13);
  localparam logic [COM_SIZE-1:0] EXE_MFHI  = COM_SIZE'(14);
  localparam logic [COM_SIZE-1:0] EXE_MFLO  = COM_SIZE'(15);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative multiply/divide with HI/LO registers, start/busy/done handshake.
// Divider datapath is compiled in only when ALU_DIV_EN is defined.
module alu_muldiv_core
  import alu_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [COM_SIZE-1:0] cmd,
  input  logic [SIZE-1:0]     val1,
  input  logic [SIZE-1:0]     val2,
  output logic                busy,
  output logic                done,
  output logic [SIZE-1:0]     hi,
  output logic [SIZE-1:0]     lo
);

  localparam int unsigned CntW = $clog2(SIZE);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Upper half: partial product / remainder; lower half: multiplier / dividend->quotient.
  logic [2*SIZE-1:0] acc_q, acc_d;
  logic [SIZE-1:0]   opb_q, opb_d;
  logic              is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic              div_zero_q, div_zero_d, done_q, done_d;
  logic [SIZE-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic              is_mul_cmd, div_code, is_div_cmd, div_skip, signed_op, sign_a, sign_b;
  logic [SIZE-1:0]   mag_a, mag_b, quo_fix, rem_fix;
  logic [SIZE:0]     mul_sum;
  logic [2*SIZE-1:0] mul_step, div_step, prod_fix;

  assign is_mul_cmd = (cmd == EXE_MULT) || (cmd == EXE_MULTU);
  assign div_code   = (cmd == EXE_DIV) || (cmd == EXE_DIVU);
  assign signed_op  = (cmd == EXE_MULT) || (cmd == EXE_DIV);
  assign sign_a     = signed_op & val1[SIZE-1];
  assign sign_b     = signed_op & val2[SIZE-1];
  assign mag_a      = sign_a ? -val1 : val1;
  assign mag_b      = sign_b ? -val2 : val2;

  assign mul_sum  = {1'b0, acc_q[2*SIZE-1:SIZE]} + {1'b0, (acc_q[0] ? opb_q : {SIZE{1'b0}})};
  assign mul_step = {mul_sum, acc_q[SIZE-1:1]};

`ifdef ALU_DIV_EN
  logic [SIZE:0] div_shift, div_diff;
  logic          div_ok;
  assign is_div_cmd = div_code;
  assign div_skip   = 1'b0;
  assign div_shift  = acc_q[2*SIZE-1:SIZE-1];
  assign div_diff   = div_shift - {1'b0, opb_q};
  assign div_ok     = ~div_diff[SIZE];
  assign div_step   = {(div_ok ? div_diff[SIZE-1:0] : div_shift[SIZE-1:0]),
                       acc_q[SIZE-2:0], div_ok};
`else
  assign is_div_cmd = 1'b0;
  assign div_skip   = div_code;
  assign div_step   = mul_step;
`endif

  assign prod_fix = neg_q ? -acc_q : acc_q;
  // Divide by zero leaves the raw dividend as remainder; the quotient is forced to all ones.
  assign quo_fix  = div_zero_q ? {SIZE{1'b1}} :
                    (neg_q ? -acc_q[SIZE-1:0] : acc_q[SIZE-1:0]);
  assign rem_fix  = neg_rem_q ? -acc_q[2*SIZE-1:SIZE] : acc_q[2*SIZE-1:SIZE];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (is_mul_cmd || is_div_cmd)) begin
          state_d    = StRun;
          cnt_d      = '0;
          acc_d      = {{SIZE{1'b0}}, mag_a};
          opb_d      = mag_b;
          is_div_d   = is_div_cmd;
          neg_d      = sign_a ^ sign_b;
          neg_rem_d  = sign_a;
          div_zero_d = (val2 == '0);
        end else if (start && div_skip) begin
          done_d = 1'b1;
        end
      end
      StRun: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(SIZE - 1)) state_d = StFin;
      end
      StFin: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle ops plus iterative MULT/DIV into HI/LO.
// Define ALU_DIV_EN to compile in the divider (see alu_muldiv_core).
module alu_iter #(
  parameter int unsigned SIZE     = 32,
  parameter int unsigned COM_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [COM_SIZE-1:0] EXE_CMD,
  input  logic [SIZE-1:0]     val1,
  input  logic [SIZE-1:0]     val2,
  output logic [SIZE-1:0]     aluOut,
  output logic                busy,
  output logic                done,
  output logic [SIZE-1:0]     hiOut,
  output logic [SIZE-1:0]     loOut
);
  import alu_pkg::*;

  localparam int unsigned ShW = $clog2(SIZE);

  logic [ShW-1:0] shamt;
  assign shamt = val2[ShW-1:0];

  alu_muldiv_core #(
    .SIZE (SIZE)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cmd   (EXE_CMD),
    .val1  (val1),
    .val2  (val2),
    .busy  (busy),
    .done  (done),
    .hi    (hiOut),
    .lo    (loOut)
  );

  // MFHI/MFLO read the architectural registers, so they see pre-operation values while busy.
  always_comb begin
    aluOut = '0;
    case (EXE_CMD)
      EXE_ADD:  aluOut = val1 + val2;
      EXE_SUB:  aluOut = val1 - val2;
      EXE_AND:  aluOut = val1 & val2;
      EXE_OR:   aluOut = val1 | val2;
      EXE_NOR:  aluOut = ~(val1 | val2);
      EXE_XOR:  aluOut = val1 ^ val2;
      EXE_SLA,
      EXE_SLL:  aluOut = val1 << shamt;
      EXE_SRA:  aluOut = $unsigned($signed(val1) >>> shamt);
      EXE_SRL:  aluOut = val1 >> shamt;
      EXE_MFHI: aluOut = hiOut;
      EXE_MFLO: aluOut = loOut;
      default:  aluOut = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter (SIZE = 32).
module tb_alu_iter;
  import alu_pkg::*;

  localparam int unsigned SIZE = 32;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [3:0]      EXE_CMD;
  logic [SIZE-1:0] val1, val2, aluOut, hiOut, loOut;
  logic            busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_iter #(.SIZE(SIZE), .COM_SIZE(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .EXE_CMD (EXE_CMD),
    .val1    (val1),
    .val2    (val2),
    .aluOut  (aluOut),
    .busy    (busy),
    .done    (done),
    .hiOut   (hiOut),
    .loOut   (loOut)
  );

  // Drive a launch; returns #1 into cycle 1.
  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; EXE_CMD = op; val1 = a; val2 = b;
    @(posedge clk); #1;
    start = 1'b0; EXE_CMD = EXE_ADD; val1 = '0; val2 = '0;
  endtask

  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; EXE_CMD = EXE_ADD; val1 = '0; val2 = '0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (hiOut !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", hiOut); end
    total++; if (loOut !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", loOut); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [3:0]  ops [12] = '{EXE_ADD, EXE_SUB, EXE_AND, EXE_OR, EXE_NOR, EXE_XOR,
                              EXE_SRA, EXE_SRL, EXE_SLL, EXE_SLA, EXE_SRA, EXE_MULT};
    logic [31:0] a   [12] = '{32'd5, 32'd3, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0, 32'hF0F0F0F0,
                              32'h80000000, 32'h80000000, 32'h1, 32'h3, 32'h7FFFFFF0, 32'd5};
    logic [31:0] b   [12] = '{32'd3, 32'd5, 32'hFF00FF00, 32'hFF00FF00, 32'h0, 32'hFF00FF00,
                              32'd4, 32'd4, 32'd31, 32'h24, 32'd4, 32'd5};
    logic [31:0] exp [12] = '{32'd8, 32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0, 32'hFFFFFFFF,
                              32'h0FF00FF0, 32'hF8000000, 32'h08000000, 32'h80000000, 32'h30,
                              32'h07FFFFFF, 32'h0};
    for (int i = 0; i < 12; i++) begin
      EXE_CMD = ops[i]; val1 = a[i]; val2 = b[i];
      #1;
      total++;
      if (aluOut !== exp[i]) begin
        bad++; $display("FAIL single_op[%0d] cmd=%0d got=%h want=%h", i, ops[i], aluOut, exp[i]);
      end
    end
    EXE_CMD = EXE_ADD; val1 = '0; val2 = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int cyc;
    launch(EXE_MULT, 32'hFFFFFFFF, 32'd2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mult_busy1 got=%b want=1", busy); end
    wait_done(1, cyc);
    total++; if (cyc != 34) begin bad++; $display("FAIL mult_latency got=%0d want=34", cyc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mult_busy_done got=%b want=0", busy); end
    total++; if (hiOut !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", hiOut); end
    total++; if (loOut !== 32'hFFFFFFFE) begin bad++; $display("FAIL mult_lo got=%h want=fffffffe", loOut); end
    EXE_CMD = EXE_MFHI; #1;
    total++; if (aluOut !== 32'hFFFFFFFF) begin bad++; $display("FAIL mfhi got=%h want=ffffffff", aluOut); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b want=0", done); end
    launch(EXE_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_done(1, cyc);
    total++; if (cyc != 34) begin bad++; $display("FAIL multu_latency got=%0d want=34", cyc); end
    total++; if (hiOut !== 32'h1) begin bad++; $display("FAIL multu_hi got=%h want=1", hiOut); end
    total++; if (loOut !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_lo got=%h want=fffffffe", loOut); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy();
    int cyc;
    launch(EXE_MULTU, 32'd3, 32'd5);
    EXE_CMD = EXE_MFLO; #1;
    total++; if (aluOut !== 32'hFFFFFFFE) begin bad++; $display("FAIL mflo_busy got=%h want=fffffffe", aluOut); end
    EXE_CMD = EXE_ADD; val1 = 32'd10; val2 = 32'd20; #1;
    total++; if (aluOut !== 32'd30) begin bad++; $display("FAIL add_busy got=%h want=1e", aluOut); end
    start = 1'b1; EXE_CMD = EXE_MULT; val1 = 32'd7; val2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; EXE_CMD = EXE_ADD;
    wait_done(2, cyc);
    total++; if (cyc != 34) begin bad++; $display("FAIL ignore_latency got=%0d want=34", cyc); end
    total++; if (loOut !== 32'd15) begin bad++; $display("FAIL ignore_lo got=%h want=f", loOut); end
    total++; if (hiOut !== 32'd0) begin bad++; $display("FAIL ignore_hi got=%h want=0", hiOut); end
  endtask

  // Entered in the done cycle of test_busy.
  task automatic test_back_to_back();
    int cyc;
    launch(EXE_MULT, 32'hFFFFFFFD, 32'd4);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
    wait_done(1, cyc);
    total++; if (cyc != 34) begin bad++; $display("FAIL b2b_latency got=%0d want=34", cyc); end
    total++; if (hiOut !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_hi got=%h want=ffffffff", hiOut); end
    total++; if (loOut !== 32'hFFFFFFF4) begin bad++; $display("FAIL b2b_lo got=%h want=fffffff4", loOut); end
  endtask

`ifdef ALU_DIV_EN
  task automatic test_div();
    logic [3:0]  ops [4] = '{EXE_DIV, EXE_DIVU, EXE_DIV, EXE_DIV};
    logic [31:0] a   [4] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFF9};
    logic [31:0] b   [4] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [31:0] elo [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] ehi [4] = '{32'hFFFFFFFF, 32'd7, 32'h0, 32'hFFFFFFF9};
    int cyc;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      launch(ops[i], a[i], b[i]);
      wait_done(1, cyc);
      total++; if (cyc != 34) begin bad++; $display("FAIL div_latency[%0d] got=%0d want=34", i, cyc); end
      total++; if (loOut !== elo[i]) begin bad++; $display("FAIL div_lo[%0d] got=%h want=%h", i, loOut, elo[i]); end
      total++; if (hiOut !== ehi[i]) begin bad++; $display("FAIL div_hi[%0d] got=%h want=%h", i, hiOut, ehi[i]); end
    end
  endtask
`else
  task automatic test_nodiv();
    logic saw_busy = 1'b0;
    @(posedge clk); #1;
    launch(EXE_DIV, 32'd9, 32'd3);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL nodiv_done got=%b want=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL nodiv_busy got=%b want=0", busy); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL nodiv_done2 got=%b want=0", done); end
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b0) saw_busy = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (saw_busy) begin bad++; $display("FAIL nodiv_busy_seen got=1 want=0"); end
    total++; if (hiOut !== 32'hFFFFFFFF) begin bad++; $display("FAIL nodiv_hi got=%h want=ffffffff", hiOut); end
    total++; if (loOut !== 32'hFFFFFFF4) begin bad++; $display("FAIL nodiv_lo got=%h want=fffffff4", loOut); end
  endtask
`endif

  task automatic test_reset_mid();
    logic saw_done = 1'b0;
    @(posedge clk); #1;
    launch(EXE_MULT, 32'd5, 32'd6);
    repeat (9) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre got=%b want=1", busy); end
    rst = 1'b1; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    total++; if (hiOut !== 32'h0) begin bad++; $display("FAIL mid_hi got=%h want=0", hiOut); end
    total++; if (loOut !== 32'h0) begin bad++; $display("FAIL mid_lo got=%h want=0", loOut); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (saw_done) begin bad++; $display("FAIL mid_done_seen got=1 want=0"); end
    total++; if (loOut !== 32'h0) begin bad++; $display("FAIL mid_lo_after got=%h want=0", loOut); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mult();
    test_busy();
    test_back_to_back();
`ifdef ALU_DIV_EN
    test_div();
`else
    test_nodiv();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
